// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns load-use, memory-busy, redirect and halt requests into
// per-stage pipeline enables and bubble injects. Optional macro: STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Reg1_EX_EXFwrd_Stall,
  input  logic             Reg2_EX_EXFwrd_Stall,
  input  logic             exe_uses_r1,
  input  logic             exe_uses_r2,
  input  logic             redirect_ex,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_bubble,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             halted,
  output logic             err_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ld_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_HOLD  = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_r;
  logic [CNT_W-1:0] tmoCnt_r;
  logic             errSticky_r;

  logic ldUse_s, haltReq_s, dmemStall_s, ldStall_s, redirTake_s, imemStall_s, tmoHit_s;

  // Resolve which single request is honoured this cycle, in priority order.
  always_comb begin
    ldUse_s     = (Reg1_EX_EXFwrd_Stall & exe_uses_r1) | (Reg2_EX_EXFwrd_Stall & exe_uses_r2);
    haltReq_s   = (state_r == HALTED) | halt_wb;
    dmemStall_s = ~haltReq_s & dmem_busy;
    // The load-use stall is masked for the one cycle after it was serviced.
    ldStall_s   = ~haltReq_s & ~dmem_busy & ldUse_s & (state_r != LD_HOLD);
    redirTake_s = ~haltReq_s & ~dmem_busy & ~ldStall_s & redirect_ex;
    imemStall_s = ~haltReq_s & ~dmem_busy & ~ldStall_s & ~redirect_ex & imem_busy;
    tmoHit_s    = dmemStall_s & (tmoCnt_r == TMO_LIM);
  end

  // Same-cycle enable/bubble decode of the honoured request.
  always_comb begin
    pc_en           = 1'b1;
    pc_sel_redirect = 1'b0;
    ifid_en         = 1'b1;
    idex_en         = 1'b1;
    exmem_en        = 1'b1;
    memwb_en        = 1'b1;
    ifid_bubble     = 1'b0;
    idex_bubble     = 1'b0;
    exmem_bubble    = 1'b0;
    memwb_bubble    = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_bubble  = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
    end else if (haltReq_s) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dmemStall_s) begin
      // WB keeps clocking but takes a NOP so the stalled MEM op is not retired twice.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ldStall_s) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = 1'b1;
    end else if (redirTake_s) begin
      pc_sel_redirect = 1'b1;
      ifid_bubble     = 1'b1;
      idex_bubble     = 1'b1;
    end else if (imemStall_s) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_sel_redirect = 1'b0;
    end
  end

  // Control state: halt is terminal until reset; MEM_WAIT/LD_HOLD otherwise act as RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        HALTED: state_r <= HALTED;
        RUN, LD_HOLD, MEM_WAIT: begin
          if (halt_wb) begin
            state_r <= HALTED;
          end else if (dmem_busy) begin
            state_r <= MEM_WAIT;
          end else if (ldStall_s) begin
            state_r <= LD_HOLD;
          end else begin
            state_r <= RUN;
          end
        end
        default: state_r <= RUN;
      endcase
    end
  end

  // Consecutive data-memory busy counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmoCnt_r    <= {CNT_W{1'b0}};
      errSticky_r <= 1'b0;
    end else begin
      if (dmemStall_s) begin
        tmoCnt_r <= (tmoCnt_r == CNT_MAX) ? tmoCnt_r : tmoCnt_r + CNT_ONE;
      end else begin
        tmoCnt_r <= {CNT_W{1'b0}};
      end
      errSticky_r <= errSticky_r | tmoHit_s;
    end
  end

  assign halted      = (state_r == HALTED);
  assign err_timeout = errSticky_r | tmoHit_s;

`ifdef STALL_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic inc);
    logic [CNT_W-1:0] r;
    if (inc && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Saturating stall/flush statistics; halt masks every honoured event so they freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_stall_cnt  <= {CNT_W{1'b0}};
      mem_stall_cnt <= {CNT_W{1'b0}};
      flush_cnt     <= {CNT_W{1'b0}};
    end else begin
      ld_stall_cnt  <= satInc(ld_stall_cnt, ldStall_s);
      mem_stall_cnt <= satInc(mem_stall_cnt, dmemStall_s);
      flush_cnt     <= satInc(flush_cnt, redirTake_s);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, directed corner sequences
// and randomized stimulus against a priority-rule reference model.
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic r1s; logic r2s; logic u1; logic u2;
    logic redir; logic imem; logic dmem; logic halt;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [11:0] exp;
  } vec_t;

  logic clk, rst_n;
  stim_t curS;

  logic pc_en, pc_sel_redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble, halted, err_timeout;
  logic pc_en4, pc_sel4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
  logic ifid_b4, idex_b4, exmem_b4, memwb_b4, halted4, err4;

  wire [11:0] outV = {pc_en, pc_sel_redirect, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble, halted, err_timeout};

`ifdef STALL_PERF_CNT_EN
  logic [15:0] ld_stall_cnt, mem_stall_cnt, flush_cnt;
  logic [15:0] ldCnt4, memCnt4, flCnt4;
  logic [1:0]  ldCntC, memCntC, flCntC;
  logic pcC, selC, ifC, idC, exC, mwC, ifbC, idbC, exbC, mwbC, hC, eC;
`endif

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .Reg1_EX_EXFwrd_Stall(curS.r1s), .Reg2_EX_EXFwrd_Stall(curS.r2s),
    .exe_uses_r1(curS.u1), .exe_uses_r2(curS.u2), .redirect_ex(curS.redir),
    .imem_busy(curS.imem), .dmem_busy(curS.dmem), .halt_wb(curS.halt),
    .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_bubble(ifid_bubble),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble),
    .halted(halted), .err_timeout(err_timeout)
`ifdef STALL_PERF_CNT_EN
    , .ld_stall_cnt(ld_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stall_ctrl #(.CNT_W(16), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .Reg1_EX_EXFwrd_Stall(curS.r1s), .Reg2_EX_EXFwrd_Stall(curS.r2s),
    .exe_uses_r1(curS.u1), .exe_uses_r2(curS.u2), .redirect_ex(curS.redir),
    .imem_busy(curS.imem), .dmem_busy(curS.dmem), .halt_wb(curS.halt),
    .pc_en(pc_en4), .pc_sel_redirect(pc_sel4), .ifid_en(ifid_en4), .idex_en(idex_en4),
    .exmem_en(exmem_en4), .memwb_en(memwb_en4), .ifid_bubble(ifid_b4),
    .idex_bubble(idex_b4), .exmem_bubble(exmem_b4), .memwb_bubble(memwb_b4),
    .halted(halted4), .err_timeout(err4)
`ifdef STALL_PERF_CNT_EN
    , .ld_stall_cnt(ldCnt4), .mem_stall_cnt(memCnt4), .flush_cnt(flCnt4)
`endif
  );

`ifdef STALL_PERF_CNT_EN
  pipe_stall_ctrl #(.CNT_W(2), .TIMEOUT(3)) dutC (
    .clk(clk), .rst_n(rst_n),
    .Reg1_EX_EXFwrd_Stall(curS.r1s), .Reg2_EX_EXFwrd_Stall(curS.r2s),
    .exe_uses_r1(curS.u1), .exe_uses_r2(curS.u2), .redirect_ex(curS.redir),
    .imem_busy(curS.imem), .dmem_busy(curS.dmem), .halt_wb(curS.halt),
    .pc_en(pcC), .pc_sel_redirect(selC), .ifid_en(ifC), .idex_en(idC),
    .exmem_en(exC), .memwb_en(mwC), .ifid_bubble(ifbC), .idex_bubble(idbC),
    .exmem_bubble(exbC), .memwb_bubble(mwbC), .halted(hC), .err_timeout(eC),
    .ld_stall_cnt(ldCntC), .mem_stall_cnt(memCntC), .flush_cnt(flCntC)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state: what has happened so far, in spec terms.
  bit mHalted, mHold, mErr, mErr4;
  int mTmo, mLd, mMem, mFl, mLdC, mMemC, mFlC;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit ldUse(input stim_t s);
    return (s.r1s && s.u1) || (s.r2s && s.u2);
  endfunction

  // Expected {pc_en,pc_sel,ifid,idex,exmem,memwb, 4 bubbles, halted, err}.
  function automatic logic [11:0] refOut(input stim_t s, input bit err, input int lim);
    if (mHalted || s.halt) return {6'b000000, 4'b0000, mHalted, err};
    if (s.dmem)            return {6'b000001, 4'b0001, 1'b0, err || (mTmo == lim)};
    if (ldUse(s) && !mHold) return {6'b000011, 4'b0010, 1'b0, err};
    if (s.redir)           return {6'b111111, 4'b1100, 1'b0, err};
    if (s.imem)            return {6'b000111, 4'b0100, 1'b0, err};
    return {6'b101111, 4'b0000, 1'b0, err};
  endfunction

  function automatic int sat(input int v, input bit inc, input int maxV);
    return (inc && v < maxV) ? v + 1 : v;
  endfunction

  task automatic modelReset();
    mHalted = 0; mHold = 0; mErr = 0; mErr4 = 0; mTmo = 0;
    mLd = 0; mMem = 0; mFl = 0; mLdC = 0; mMemC = 0; mFlC = 0;
  endtask

  task automatic modelEdge(input stim_t s);
    bit act, memH, ldH, flH;
    act  = !mHalted && !s.halt;
    memH = act && s.dmem;
    ldH  = act && !s.dmem && ldUse(s) && !mHold;
    flH  = act && !s.dmem && !ldH && s.redir;
    mErr  = mErr  || (memH && mTmo == 255);
    mErr4 = mErr4 || (memH && mTmo == 4);
    mTmo  = memH ? mTmo + 1 : 0;
    mHold = ldH;
    if (s.halt) mHalted = 1;
    mLd  = sat(mLd, ldH, 65535);  mMem  = sat(mMem, memH, 65535);  mFl  = sat(mFl, flH, 65535);
    mLdC = sat(mLdC, ldH, 3);     mMemC = sat(mMemC, memH, 3);     mFlC = sat(mFlC, flH, 3);
  endtask

  task automatic checkModel();
    logic [11:0] e4;
    e4 = refOut(curS, mErr4, 4);
    chk("out", {20'd0, outV}, {20'd0, refOut(curS, mErr, 255)});
    chk("err4", {31'd0, err4}, {31'd0, e4[0]});
`ifdef STALL_PERF_CNT_EN
    chk("ldCnt", {16'd0, ld_stall_cnt}, mLd);
    chk("memCnt", {16'd0, mem_stall_cnt}, mMem);
    chk("flCnt", {16'd0, flush_cnt}, mFl);
    chk("flCntC", {30'd0, flCntC}, mFlC);
    chk("ldCntC", {30'd0, ldCntC}, mLdC);
    chk("memCntC", {30'd0, memCntC}, mMemC);
`endif
  endtask

  // One clock: drive right after the edge, check mid-cycle, advance the model at the edge.
  task automatic cycle(input stim_t s);
    curS = s;
    @(negedge clk);
    checkModel();
    @(posedge clk);
    modelEdge(s);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    chk("rst_out", {20'd0, outV}, {20'd0, 12'b000000_1111_00});
    chk("rst_err4", {31'd0, err4}, 32'd0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  stim_t s;
  int busyLeft, haltCycles;

  initial begin
    curS = stim_t'(8'h00);
    rst_n = 1'b0;
    tbl[0]  = '{s: stim_t'(8'b0000_0000), exp: 12'b101111_0000_00};
    tbl[1]  = '{s: stim_t'(8'b1010_0000), exp: 12'b000011_0010_00};
    tbl[2]  = '{s: stim_t'(8'b1010_0000), exp: 12'b101111_0000_00};
    tbl[3]  = '{s: stim_t'(8'b1000_0000), exp: 12'b101111_0000_00};
    tbl[4]  = '{s: stim_t'(8'b0101_1000), exp: 12'b000011_0010_00};
    tbl[5]  = '{s: stim_t'(8'b0000_1000), exp: 12'b111111_1100_00};
    tbl[6]  = '{s: stim_t'(8'b0000_0100), exp: 12'b000111_0100_00};
    tbl[7]  = '{s: stim_t'(8'b0000_1100), exp: 12'b111111_1100_00};
    tbl[8]  = '{s: stim_t'(8'b1010_0010), exp: 12'b000001_0001_00};
    tbl[9]  = '{s: stim_t'(8'b1010_0000), exp: 12'b000011_0010_00};
    tbl[10] = '{s: stim_t'(8'b1010_0100), exp: 12'b000111_0100_00};
    tbl[11] = '{s: stim_t'(8'b0101_0000), exp: 12'b000011_0010_00};
    tbl[12] = '{s: stim_t'(8'b0101_1000), exp: 12'b111111_1100_00};

    doReset();
    for (int i = 0; i < 13; i++) begin
      curS = tbl[i].s;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {20'd0, outV}, {20'd0, tbl[i].exp});
      @(posedge clk);
      modelEdge(tbl[i].s);
      #1;
    end

    // Short dmem freeze, then a 6-cycle one that trips the TIMEOUT=4 instance.
    for (int i = 0; i < 3; i++) cycle(stim_t'(8'b0000_0010));
    cycle(stim_t'(8'b0000_0000));
    chk("no_tmo", {31'd0, err_timeout}, 32'd0);
    for (int i = 0; i < 6; i++) cycle(stim_t'(8'b0000_0010));
    cycle(stim_t'(8'b0000_0000));
    chk("tmo4_sticky", {31'd0, err4}, 32'd1);
    chk("tmo255_clear", {31'd0, err_timeout}, 32'd0);

    // Reset asserted mid-stream while memory is busy.
    curS = stim_t'(8'b0000_0010);
    #2;
    doReset();
    cycle(stim_t'(8'b0000_0000));

    // Perf mix: 2 load stalls, 3 dmem cycles, 1 redirect, then 4 more redirects.
    cycle(stim_t'(8'b1010_0000));
    cycle(stim_t'(8'b0000_0000));
    cycle(stim_t'(8'b0101_0000));
    for (int i = 0; i < 3; i++) cycle(stim_t'(8'b0000_0010));
    cycle(stim_t'(8'b0000_1000));
    cycle(stim_t'(8'b0000_0000));
`ifdef STALL_PERF_CNT_EN
    chk("perf_ld2", {16'd0, ld_stall_cnt}, 32'd2);
    chk("perf_mem3", {16'd0, mem_stall_cnt}, 32'd3);
    chk("perf_fl1", {16'd0, flush_cnt}, 32'd1);
`endif
    for (int i = 0; i < 4; i++) cycle(stim_t'(8'b0000_1000));
    cycle(stim_t'(8'b0000_0000));
`ifdef STALL_PERF_CNT_EN
    chk("perf_flsat", {30'd0, flCntC}, 32'd3);
`endif

    // Halt during an imem stall; later requests are ignored until reset.
    cycle(stim_t'(8'b0000_0101));
    chk("halted", {31'd0, halted}, 32'd1);
    cycle(stim_t'(8'b0000_1000));
    cycle(stim_t'(8'b1010_0000));
    cycle(stim_t'(8'b0000_0010));
    chk("halted_stuck", {31'd0, halted}, 32'd1);
    doReset();
    cycle(stim_t'(8'b0000_0000));

    // Randomized traffic with dmem bursts and rare halts.
    busyLeft = 0;
    haltCycles = 0;
    for (int n = 0; n < 3000; n++) begin
      s = stim_t'(8'($urandom));
      s.halt = ($urandom_range(0, 299) == 0);
      if (busyLeft == 0 && $urandom_range(0, 5) == 0) busyLeft = $urandom_range(1, 7);
      s.dmem = (busyLeft > 0);
      if (busyLeft > 0) busyLeft--;
      cycle(s);
      haltCycles = mHalted ? haltCycles + 1 : 0;
      if (haltCycles > 3) begin
        doReset();
        haltCycles = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
